// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD requester.
// State encoding and default sizing live here.
package gcd_pkg;

  localparam int GCD_WIDTH   = 5;
  localparam int GCD_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_WAIT,
    ST_CAPTURE
  } state_e;

  function automatic logic is_busy(state_e s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/gcd_requester_rise_detect.sv
// Registered rising-edge detector for the go button.
// History resets to 1 so a held level never fires.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // next history value is simply the current level
  always_comb prev_d = d;

  // history flop, reset high to mask a held button
  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= prev_d;
  end

  // edge is current high with previous low
  always_comb rise = d & ~prev_q;

endmodule

// File: rtl/gcd_requester.sv
// Initiator for the GCD core load/done handshake.
// Screens zero operands, guards with a watchdog.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] a_sw,
  input  logic [WIDTH-1:0] b_sw,
  output logic             core_load,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic [WIDTH-1:0] core_result,
  input  logic             core_done,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy,
  output logic             timeout_err,
  output logic [7:0]       op_count
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // LOAD cycle counts toward the budget and
  // the exit is registered, hence the -2.
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 2);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             load_q, load_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             terr_q, terr_d;
  logic [7:0]       ops_q, ops_d;

  logic go_rise;
  logic zero_op;
  logic waiting;
  logic tmo_hit;

  rise_detect u_go_edge (
    .clk   (clk),
    .reset (reset),
    .d     (go),
    .rise  (go_rise)
  );

  // request screening and watchdog terminal count
  always_comb begin
    zero_op = (a_sw == '0) || (b_sw == '0);
    waiting = (state_q == ST_ARM) || (state_q == ST_WAIT);
    tmo_hit = waiting && (cnt_q == TERM);
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic; timeout beats a same-cycle done
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go_rise && !zero_op) state_d = ST_LOAD;
      end
      ST_LOAD: state_d = ST_ARM;
      ST_ARM: begin
        if (tmo_hit)         state_d = ST_IDLE;
        else if (!core_done) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tmo_hit)        state_d = ST_IDLE;
        else if (core_done) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // output and datapath next values
  always_comb begin
    cnt_d    = cnt_q;
    load_d   = 1'b0;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    valid_d  = valid_q;
    terr_d   = terr_q;
    ops_d    = ops_q;
    busy_d   = is_busy(state_d);
    unique case (state_q)
      ST_IDLE: begin
        if (go_rise) begin
          a_d     = a_sw;
          b_d     = b_sw;
          valid_d = 1'b0;
          terr_d  = 1'b0;
          if (zero_op) begin
            result_d = a_sw | b_sw;
            valid_d  = 1'b1;
            ops_d    = ops_q + 8'd1;
          end else begin
            load_d = 1'b1;
            cnt_d  = '0;
          end
        end
      end
      ST_ARM, ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (tmo_hit) begin
          terr_d   = 1'b1;
          result_d = '0;
          valid_d  = 1'b0;
        end
      end
      ST_CAPTURE: begin
        result_d = core_result;
        valid_d  = 1'b1;
        ops_d    = ops_q + 8'd1;
      end
      default: ;
    endcase
  end

  // registered outputs and transaction state
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      load_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      ops_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
      ops_q    <= ops_d;
    end
  end

  assign core_load   = load_q;
  assign core_a      = a_q;
  assign core_b      = b_q;
  assign result      = result_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign op_count    = ops_q;

endmodule

// File: tb/tb_gcd_requester.sv
// Self-checking bench for gcd_requester.
// Includes a behavioural GCD core responder.
module tb_gcd_requester;

  localparam int W  = 5;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         go;
  logic [W-1:0] a_sw, b_sw;
  logic         core_load;
  logic [W-1:0] core_a, core_b;
  logic [W-1:0] core_result;
  logic         core_done;
  logic [W-1:0] result;
  logic         valid, busy, timeout_err;
  logic [7:0]   op_count;

  int errors = 0;
  int checks = 0;
  int model_ops = 0;

  int core_lat   = 4;
  bit core_never = 1'b0;
  bit core_stale = 1'b0;
  int k;
  bit active;
  int res_hold;

  gcd_requester #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .a_sw        (a_sw),
    .b_sw        (b_sw),
    .core_load   (core_load),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_result (core_result),
    .core_done   (core_done),
    .result      (result),
    .valid       (valid),
    .busy        (busy),
    .timeout_err (timeout_err),
    .op_count    (op_count)
  );

  always #5 clk = ~clk;

  function automatic int ref_gcd(int a, int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // behavioural core: done is a level held until next load
  always @(posedge clk) begin
    if (reset) begin
      core_done   <= 1'b0;
      core_result <= '0;
      k           <= 0;
      active      <= 1'b0;
    end else if (core_load) begin
      k        <= 1;
      active   <= 1'b1;
      res_hold <= ref_gcd(int'(core_a), int'(core_b));
      if (!core_stale) core_done <= 1'b0;
    end else if (active) begin
      k <= k + 1;
      if (core_stale && k == 2) core_done <= 1'b0;
      if (!core_never && k == core_lat) begin
        core_done   <= 1'b1;
        core_result <= W'(res_hold);
        active      <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_load"}, int'(core_load), 0);
    chk({tag, "_core_a"}, int'(core_a), 0);
    chk({tag, "_core_b"}, int'(core_b), 0);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_terr"}, int'(timeout_err), 0);
    chk({tag, "_ops"}, int'(op_count), 0);
  endtask

  // one transaction from a negedge; returns at a negedge
  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input int exp_res,
                        input string name);
    int loads;
    int j;
    core_lat = lat;
    a_sw = a;
    b_sw = b;
    go = 1'b1;
    @(negedge clk);
    if (a == 0 || b == 0) begin
      model_ops++;
      chk({name, "_byp_valid"}, int'(valid), 1);
      chk({name, "_byp_result"}, int'(result), exp_res);
      chk({name, "_byp_noload"}, int'(core_load), 0);
      chk({name, "_byp_busy"}, int'(busy), 0);
    end else begin
      chk({name, "_load"}, int'(core_load), 1);
      chk({name, "_valid_clr"}, int'(valid), 0);
      loads = 1;
      j = 0;
      a_sw = ~a;
      b_sw = ~b;
      while (!valid && j < 60) begin
        @(negedge clk);
        j++;
        if (core_load) loads++;
      end
      model_ops++;
      chk({name, "_latency"}, j, lat + 3);
      chk({name, "_loads"}, loads, 1);
      chk({name, "_result"}, int'(result), exp_res);
      chk({name, "_busy"}, int'(busy), 0);
    end
    chk({name, "_ops"}, int'(op_count), model_ops % 256);
    go = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    int           res;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int first;
    int loads;
    logic [W-1:0] ra, rb;
    int rl;

    vecs[0] = '{5'd30, 5'd10, 4, 10};
    vecs[1] = '{5'd0,  5'd12, 1, 12};
    vecs[2] = '{5'd0,  5'd0,  1, 0};
    vecs[3] = '{5'd12, 5'd18, 3, 6};
    vecs[4] = '{5'd31, 5'd1,  2, 1};
    vecs[5] = '{5'd7,  5'd0,  1, 7};
    vecs[6] = '{5'd21, 5'd14, 8, 7};

    reset = 1'b1;
    go    = 1'b1;
    a_sw  = 5'd3;
    b_sw  = 5'd4;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst_held_go");
    go = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      do_txn(vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].res,
             $sformatf("vec%0d", i));

    // stale done from the previous op must be ignored
    core_stale = 1'b1;
    chk("stale_pre_done", int'(core_done), 1);
    do_txn(5'd25, 5'd15, 6, 5, "stale");
    core_stale = 1'b0;

    // core never answers; extra go during WAIT ignored
    core_never = 1'b1;
    a_sw = 5'd9;
    b_sw = 5'd6;
    go = 1'b1;
    @(negedge clk);
    chk("to_load", int'(core_load), 1);
    loads = 1;
    first = -1;
    for (int j = 1; j <= TO + 4; j++) begin
      if (j == 3) go = 1'b0;
      if (j == 5) begin
        go = 1'b1;
        a_sw = 5'd1;
      end
      @(negedge clk);
      if (core_load) loads++;
      if (j == 10) chk("to_core_a_hold", int'(core_a), 9);
      if (timeout_err && first < 0) first = j;
    end
    chk("to_cycle", first, TO);
    chk("to_loads", loads, 1);
    chk("to_result", int'(result), 0);
    chk("to_valid", int'(valid), 0);
    chk("to_busy", int'(busy), 0);
    chk("to_ops", int'(op_count), model_ops % 256);
    go = 1'b0;
    @(negedge clk);

    // reset in the middle of WAIT
    a_sw = 5'd30;
    b_sw = 5'd10;
    go = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_rst");
    reset = 1'b0;
    model_ops = 0;
    core_never = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);
    go = 1'b0;
    @(negedge clk);
    do_txn(5'd15, 5'd25, 3, 5, "post_rst");

    // randomized transactions against the reference gcd
    for (int i = 0; i < 25; i++) begin
      ra = W'($urandom_range(0, 31));
      rb = W'($urandom_range(0, 31));
      rl = int'($urandom_range(1, 10));
      do_txn(ra, rb, rl, ref_gcd(int'(ra), int'(rb)),
             $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcd_requester.md
# gcd_requester

Initiator side of the GCD core's load/done interface. Captures two operands from switch inputs on a push of `go`, issues a single-cycle `core_load` to the GCD core, waits for `core_done`, and latches the core's result for the display path. It owns operand screening (zero operands), a watchdog timeout, and a completed-transaction counter, so the core never sees an illegal request.

## Interface
- `WIDTH`, 5: operand/result width.
- `TIMEOUT`, 64: max cycles spent waiting on the core per transaction (≥ 2^WIDTH + 4).
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `go`  in  1  request level (button, already synchronised); rising edge starts a transaction.
- `a_sw`  in  WIDTH  operand A.
- `b_sw`  in  WIDTH  operand B.
- `core_load`  out  1  one-cycle load strobe to the core.
- `core_a`, `core_b`  out  WIDTH  operands presented to the core (held stable from LOAD to end of WAIT).
- `core_result`  in  WIDTH  core result.
- `core_done`  in  1  core completion level.
- `result`  out  WIDTH  last captured GCD.
- `valid`  out  1  `result` is fresh; high from capture until next accepted `go`.
- `busy`  out  1  transaction in progress.
- `timeout_err`  out  1  last transaction timed out.
- `op_count`  out  8  completed transactions (valid captures), wraps 255→0.

## Operation
- States: IDLE, LOAD, ARM, WAIT, CAPTURE.
- IDLE: on `go` rising edge (registered `go` 0 → current 1), latch `a_sw`/`b_sw` into `core_a`/`core_b`, clear `valid` and `timeout_err`.
  - If either latched operand is 0: bypass core. Next cycle `result` = `a | b` (gcd(x,0)=x, gcd(0,0)=0), `valid`=1, `op_count`+1, stay IDLE. No `core_load` pulse.
  - Otherwise → LOAD.
- LOAD: `core_load`=1 for exactly this cycle → ARM.
- ARM: wait for `core_done`=0 (stale done from previous op is never accepted) → WAIT.
- WAIT: on `core_done`=1 → CAPTURE.
- CAPTURE: `result` ← `core_result`, `valid`=1, `op_count`+1 → IDLE.
- Timeout: cycle counter cleared on entering LOAD, increments in ARM and WAIT; on reaching TIMEOUT → IDLE, `timeout_err`=1, `result`=0, `valid`=0, `op_count` unchanged.
- `busy`=1 in LOAD, ARM, WAIT, CAPTURE.
- `go` edges while `busy`=1 are ignored (not queued). Operand switch changes after latch have no effect.

## Timing
- Reset (any state, mid-transaction included): state IDLE; `core_load`=0, `core_a`=`core_b`=0, `result`=0, `valid`=0, `busy`=0, `timeout_err`=0, `op_count`=0, edge register=1 (so a held `go` after reset does not trigger).
- All outputs registered.
- Bypass latency: `go` edge cycle N → `valid` high at N+1.
- Core path: edge at N → `core_load` high at N+1 → ARM at N+2; `core_done` seen high in WAIT at cycle M → `result`/`valid` updated at M+2 (CAPTURE then IDLE outputs).
- `core_done` arriving high in the same cycle as the timeout terminal count: timeout wins.
- `go` edge in the cycle CAPTURE returns to IDLE is not seen; edge must occur while in IDLE.

## Structure
- Shared package `gcd_pkg`: state enum (IDLE, LOAD, ARM, WAIT, CAPTURE), `GCD_WIDTH`=5 constant, default `GCD_TIMEOUT`.
- Sub-module `rise_detect` (1-bit registered edge detector, sync reset to 1) for `go`.
- Timeout counter width = $clog2(TIMEOUT+1).

## Test plan
- Reset held 3 cycles with `go`=1 then release, `go` held → no transaction; all outputs 0.
- a=30, b=10, core model answers `core_done`=1 with 10 after 4 cycles → one `core_load` pulse, `result`=10, `valid`=1, `op_count`=1.
- a=0, b=12 → no `core_load`, `result`=12 one cycle after edge; a=0, b=0 → `result`=0, `valid`=1.
- Core model holds `core_done`=1 from previous op, drops it 2 cycles after load, raises with 5 → stale done ignored, `result`=5.
- Core never asserts done → `timeout_err`=1 exactly TIMEOUT cycles after LOAD, `result`=0, `op_count` unchanged; second `go` edge during WAIT ignored.
- Reset asserted during WAIT → IDLE next cycle, all outputs at reset values, following a=15, b=25 transaction returns 5.
